forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 124 ++++++++++++
 tb/tb_forward_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Tracks in-flight register writers and picks ALU operand forwarding stages; stalls ID on not-yet-ready producers.
// Latency: stall_o is combinational in the ID cycle; fwd_sel_o is registered and lands with the instruction in EX.
// Backpressure: stall_o holds IF/ID and pushes a bubble into EX; flush_i overrides a stall and also pushes a bubble.
module forward_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int MAX_LAT    = 2,
    localparam int SELW      = $clog2(FWD_STAGES + 1),
    localparam int LATW      = $clog2(MAX_LAT + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    input  logic                        issue_regwrite_i,
    input  logic [REG_AW-1:0]           issue_rd_i,
    input  logic [LATW-1:0]             issue_lat_i,
    input  logic [NUM_SRC*REG_AW-1:0]   src_addr_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic [NUM_SRC*SELW-1:0]     fwd_sel_o,
    output logic [15:0]                 stall_cnt_o
);

    // Tracker entry j describes the instruction accepted j cycles ago.
    logic [FWD_STAGES:1] trk_vld;
    logic [REG_AW-1:0]   trk_rd  [1:FWD_STAGES];
    logic [LATW-1:0]     trk_lat [1:FWD_STAGES];

    logic [LATW-1:0]           lat_in;
    logic [NUM_SRC*SELW-1:0]   sel_nxt;
    logic                      not_rdy;
    logic                      accept;
    logic                      hit;
    int                        hit_j;
    logic [LATW-1:0]           hit_lat;

    // Clamp the producer latency into 1..MAX_LAT before it enters the tracker.
    always_comb begin
        if (issue_lat_i == '0) begin
            lat_in = LATW'(1);
        end else if (int'(issue_lat_i) > MAX_LAT) begin
            lat_in = LATW'(MAX_LAT);
        end else begin
            lat_in = issue_lat_i;
        end
    end

    // Per source: youngest matching producer wins; forward if it has aged enough, otherwise flag not-ready.
    always_comb begin
        sel_nxt = '0;
        not_rdy = 1'b0;
        hit     = 1'b0;
        hit_j   = 0;
        hit_lat = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            hit     = 1'b0;
            hit_j   = 0;
            hit_lat = '0;
            // Walk oldest to youngest so the youngest match is the last one written.
            for (int j = FWD_STAGES; j >= 1; j--) begin
                if (trk_vld[j] &&
                    (trk_rd[j] == src_addr_i[n*REG_AW +: REG_AW]) &&
                    (src_addr_i[n*REG_AW +: REG_AW] != '0)) begin
                    hit     = 1'b1;
                    hit_j   = j;
                    hit_lat = trk_lat[j];
                end
            end
            if (hit) begin
                if (hit_j >= int'(hit_lat)) begin
                    sel_nxt[n*SELW +: SELW] = SELW'(hit_j);
                end else begin
                    not_rdy = 1'b1;
                end
            end
        end
    end

    // A squashed or absent instruction never stalls; reset also masks the stall.
    assign stall_o = rst_i && issue_valid_i && !flush_i && not_rdy;
    assign accept  = issue_valid_i && !stall_o && !flush_i;

    // Shift the tracker every cycle; stalls and flushes enter as bubbles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            trk_vld <= '0;
            for (int j = 1; j <= FWD_STAGES; j++) begin
                trk_rd[j]  <= '0;
                trk_lat[j] <= '0;
            end
        end else begin
            trk_vld[1] <= accept && issue_regwrite_i && (issue_rd_i != '0);
            trk_rd[1]  <= issue_rd_i;
            trk_lat[1] <= lat_in;
            for (int j = 2; j <= FWD_STAGES; j++) begin
                trk_vld[j] <= trk_vld[j-1];
                trk_rd[j]  <= trk_rd[j-1];
                trk_lat[j] <= trk_lat[j-1];
            end
        end
    end

    // Register operand selects for the instruction entering EX; bubbles read the register file.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_sel_o <= '0;
        end else if (accept) begin
            fwd_sel_o <= sel_nxt;
        end else begin
            fwd_sel_o <= '0;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: default instance for forwarding/stall behaviour,
// a deep-latency instance for counter saturation and reset mid-stall.
module tb_forward_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst;
    logic        valid, regwrite, flush;
    logic [4:0]  rd;
    logic [1:0]  lat;
    logic [9:0]  src;
    logic        stall;
    logic [3:0]  sel;
    logic [15:0] cnt;

    // Deep instance: FWD_STAGES = MAX_LAT = 16 gives 15 stall cycles out of every 16
    logic        s_rst;
    logic        s_valid, s_regwrite, s_flush;
    logic [4:0]  s_rd;
    logic [4:0]  s_lat;
    logic [9:0]  s_src;
    logic        s_stall;
    logic [9:0]  s_sel;
    logic [15:0] s_cnt;

    int checks = 0;
    int errors = 0;
    logic found;

    forward_scoreboard u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .issue_valid_i    (valid),
        .issue_regwrite_i (regwrite),
        .issue_rd_i       (rd),
        .issue_lat_i      (lat),
        .src_addr_i       (src),
        .flush_i          (flush),
        .stall_o          (stall),
        .fwd_sel_o        (sel),
        .stall_cnt_o      (cnt)
    );

    forward_scoreboard #(
        .NUM_SRC    (2),
        .REG_AW     (5),
        .FWD_STAGES (16),
        .MAX_LAT    (16)
    ) u_sat (
        .clk_i            (clk),
        .rst_i            (s_rst),
        .issue_valid_i    (s_valid),
        .issue_regwrite_i (s_regwrite),
        .issue_rd_i       (s_rd),
        .issue_lat_i      (s_lat),
        .src_addr_i       (s_src),
        .flush_i          (s_flush),
        .stall_o          (s_stall),
        .fwd_sel_o        (s_sel),
        .stall_cnt_o      (s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int v, input int rw, input int d, input int l,
                       input int s0, input int s1, input int fl);
        valid    = 1'(v);
        regwrite = 1'(rw);
        rd       = 5'(d);
        lat      = 2'(l);
        src      = {5'(s1), 5'(s0)};
        flush    = 1'(fl);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        s_rst = 1'b0;
        s_valid = 1'b0; s_regwrite = 1'b0; s_rd = '0; s_lat = '0; s_src = '0; s_flush = 1'b0;
        // In reset with a live reader of x5: nothing may stall
        drv(1, 1, 5, 1, 5, 0, 0);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel",   32'(sel),   0);
        chk("rst_cnt",   32'(cnt),   0);
        tick;
        chk("rst_stall_edge", 32'(stall), 0);
        chk("rst_cnt_edge",   32'(cnt),   0);
        rst = 1'b1;
        s_rst = 1'b1;
        drv(0, 0, 0, 1, 0, 0, 0);
        tick;

        // ALU x5 then reader of x5: forward from stage 1, no stall
        drv(1, 1, 5, 1, 0, 0, 0);
        #1 chk("alu_wr_stall", 32'(stall), 0);
        tick;
        drv(1, 0, 0, 1, 5, 0, 0);
        #1 chk("alu_rd_stall", 32'(stall), 0);
        tick;
        chk("alu_sel", 32'(sel), 1);
        chk("alu_cnt", 32'(cnt), 0);

        // Load x6 then reader: one stall, then stage 2
        drv(1, 1, 6, 2, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 6, 0, 0);
        #1 chk("load_stall", 32'(stall), 1);
        tick;
        chk("load_bubble_sel", 32'(sel), 0);
        chk("load_cnt",        32'(cnt), 1);
        #1 chk("load_retry_stall", 32'(stall), 0);
        tick;
        chk("load_sel", 32'(sel), 2);

        // Two writers of x7: youngest wins (stage 1 on src1)
        drv(1, 1, 7, 1, 0, 0, 0);
        tick;
        drv(1, 1, 7, 1, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 0, 7, 0);
        #1 chk("young_stall", 32'(stall), 0);
        tick;
        chk("young_sel", 32'(sel), 4);

        // Sources pick different stages; reader also writes x9
        drv(1, 1, 9, 1, 0, 0, 0);
        tick;
        drv(1, 1, 10, 1, 0, 0, 0);
        tick;
        drv(1, 1, 9, 1, 9, 10, 0);
        #1 chk("mix_stall", 32'(stall), 0);
        tick;
        chk("mix_sel", 32'(sel), 6);

        // Writer to x0 and non-writer of x11 are never tracked
        drv(1, 1, 0, 2, 0, 0, 0);
        tick;
        drv(1, 0, 11, 2, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 0, 11, 0);
        #1 chk("x0_stall", 32'(stall), 0);
        tick;
        chk("x0_sel", 32'(sel), 0);

        // Latency 0 treated as 1: forwardable at stage 1
        drv(1, 1, 13, 0, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 13, 0, 0);
        #1 chk("lat0_stall", 32'(stall), 0);
        tick;
        chk("lat0_sel", 32'(sel), 1);

        // Latency 3 clamped to 2: stalls once, then stage 2 on src1
        drv(1, 1, 12, 3, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 0, 12, 0);
        #1 chk("lat3_stall", 32'(stall), 1);
        tick;
        chk("lat3_cnt", 32'(cnt), 2);
        #1 chk("lat3_retry_stall", 32'(stall), 0);
        tick;
        chk("lat3_sel", 32'(sel), 8);

        // No valid instruction: no stall, bubble select
        drv(1, 1, 15, 2, 0, 0, 0);
        tick;
        drv(0, 0, 0, 1, 15, 0, 0);
        #1 chk("novld_stall", 32'(stall), 0);
        tick;
        chk("novld_sel", 32'(sel), 0);
        chk("novld_cnt", 32'(cnt), 2);

        // Flush beats stall; squashed writer of x8 leaves entry 1 empty
        drv(1, 1, 8, 2, 0, 0, 0);
        tick;
        drv(1, 1, 8, 2, 8, 0, 1);
        #1 chk("flush_stall", 32'(stall), 0);
        tick;
        chk("flush_sel", 32'(sel), 0);
        chk("flush_cnt", 32'(cnt), 2);
        drv(1, 0, 0, 1, 8, 0, 0);
        #1 chk("post_flush_stall", 32'(stall), 0);
        tick;
        chk("post_flush_sel", 32'(sel), 2);

        // Reset mid-stall discards the pending load
        drv(1, 1, 14, 2, 0, 0, 0);
        tick;
        drv(1, 0, 0, 1, 14, 0, 0);
        #1 chk("pre_rst_stall", 32'(stall), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_sel",   32'(sel),   0);
        chk("mid_rst_cnt",   32'(cnt),   0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_stall", 32'(stall), 0);
        tick;
        chk("post_rst_sel", 32'(sel), 0);
        chk("post_rst_cnt", 32'(cnt), 0);
        drv(0, 0, 0, 1, 0, 0, 0);

        // Deep instance: same load of x1 reading x1, held forever
        s_valid = 1'b1; s_regwrite = 1'b1; s_rd = 5'd1; s_lat = 5'd16; s_src = {5'd0, 5'd1};
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_early", 32'(s_cnt), 15);
        chk("sat_sel16",     32'(s_sel), 16);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_max", 32'(s_cnt), 32'hFFFF);
        repeat (32) tick;
        chk("sat_cnt_hold", 32'(s_cnt), 32'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            #1;
            if (s_stall) found = 1'b1;
        end
        chk("sat_find_stall", 32'(found), 1);
        s_rst = 1'b0;
        #1;
        chk("sat_rst_stall", 32'(s_stall), 0);
        chk("sat_rst_cnt",   32'(s_cnt),   0);
        chk("sat_rst_sel",   32'(s_sel),   0);
        @(negedge clk);
        s_rst = 1'b1;
        #1 chk("sat_release_stall", 32'(s_stall), 0);
        tick;
        chk("sat_release_cnt", 32'(s_cnt), 0);
        s_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
